// File: rtl/mem_bus_pkg.sv
// Shared definitions for the unified memory responder: FSM encoding, default base
// address and the address decode helpers.
package mem_bus_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_e;

  localparam logic [31:0] DEFAULT_ADDR_BASE = 32'h0040_0000;

  function automatic logic [31:0] word_idx(input logic [31:0] addr, input logic [31:0] base);
    return (addr - base) >> 2;
  endfunction

  // Limit is formed in 33 bits so a base near the top of the map cannot wrap.
  function automatic logic addr_ok(input logic [31:0] addr, input logic [31:0] base,
                                   input int unsigned depth);
    logic [32:0] lim;
    lim = {1'b0, base} + (33'(depth) << 2);
    return (addr[1:0] == 2'b00) && (addr >= base) && ({1'b0, addr} < lim);
  endfunction

endpackage

// File: rtl/mem_word_array.sv
// Single-port synchronous word RAM with a registered, enable-gated read port that can
// return zero instead of the stored word.
module mem_word_array #(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter int unsigned IDX_W       = $clog2(DEPTH_WORDS),
  parameter              INIT_FILE   = ""
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             we,
  input  logic             re,
  input  logic             rzero,
  input  logic [IDX_W-1:0] idx,
  input  logic [31:0]      wdata,
  output logic [31:0]      rdata
);

  logic [31:0] words [DEPTH_WORDS];

  always_ff @(posedge clk) begin
    if (we) words[idx] <= wdata;
  end

  // Read register only moves when an access enters its response cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)     rdata <= '0;
    else if (re) rdata <= rzero ? '0 : words[idx];
  end

endmodule

// File: rtl/unified_mem_responder.sv
// Bus responder for the multicycle CPU: samples the strobe-less bus, inserts LATENCY
// wait states, answers with a one-cycle mem_rdy and writes on the way back to IDLE.
module unified_mem_responder
  import mem_bus_pkg::*;
#(
  parameter logic [31:0] ADDR_BASE   = DEFAULT_ADDR_BASE,
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter int unsigned LATENCY     = 2,
  parameter              INIT_FILE   = ""
) (
  input  logic        clk,
  input  logic        sys_rst,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_wdata,
  input  logic        mem_we,
  output logic        mem_rdy,
  output logic [31:0] mem_rdata,
  output logic        bus_err
);

  localparam int unsigned IDX_W    = $clog2(DEPTH_WORDS);
  localparam logic [3:0]  CNT_INIT = (LATENCY == 0) ? 4'd0 : 4'(LATENCY - 1);

  state_e           state, state_nxt;
  logic [31:0]      a_q, wd_q;
  logic             we_q, err_q;
  logic [3:0]       cnt_q;
  logic             ld_req, rd_en, wr_en, err_now;
  logic [IDX_W-1:0] ram_idx;

  always_comb begin
    state_nxt = state;
    ld_req    = 1'b0;
    rd_en     = 1'b0;
    wr_en     = 1'b0;
    case (state)
      IDLE: begin
        ld_req = 1'b1;
        if (LATENCY == 0) begin
          state_nxt = RESP;
          rd_en     = 1'b1;
        end else begin
          state_nxt = WAIT;
        end
      end
      WAIT: begin
        // A bus that moves during the wait states cancels the access outright.
        if ((mem_addr != a_q) || (mem_we != we_q)) begin
          state_nxt = IDLE;
        end else if (cnt_q == 4'd0) begin
          state_nxt = RESP;
          rd_en     = 1'b1;
        end
      end
      RESP: begin
        state_nxt = IDLE;
        wr_en     = we_q & ~err_q;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // With zero latency the read is launched straight from the live bus in IDLE.
  assign err_now = (state == IDLE) ? ~addr_ok(mem_addr, ADDR_BASE, DEPTH_WORDS) : err_q;
  assign ram_idx = (state == IDLE) ? IDX_W'(word_idx(mem_addr, ADDR_BASE))
                                   : IDX_W'(word_idx(a_q, ADDR_BASE));

  always_ff @(posedge clk or posedge sys_rst) begin
    if (sys_rst) state <= IDLE;
    else         state <= state_nxt;
  end

  always_ff @(posedge clk or posedge sys_rst) begin
    if (sys_rst) begin
      cnt_q   <= 4'd0;
      we_q    <= 1'b0;
      err_q   <= 1'b0;
      mem_rdy <= 1'b0;
      bus_err <= 1'b0;
    end else begin
      mem_rdy <= rd_en;
      if (ld_req) begin
        we_q  <= mem_we;
        err_q <= ~addr_ok(mem_addr, ADDR_BASE, DEPTH_WORDS);
        cnt_q <= CNT_INIT;
      end else if ((state == WAIT) && (cnt_q != 4'd0)) begin
        cnt_q <= cnt_q - 4'd1;
      end
      if ((state == RESP) && err_q) bus_err <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (ld_req) begin
      a_q  <= mem_addr;
      wd_q <= mem_wdata;
    end
  end

  mem_word_array #(
    .DEPTH_WORDS(DEPTH_WORDS),
    .IDX_W      (IDX_W),
    .INIT_FILE  (INIT_FILE)
  ) u_array (
    .clk  (clk),
    .rst  (sys_rst),
    .we   (wr_en),
    .re   (rd_en),
    .rzero(err_now),
    .idx  (ram_idx),
    .wdata(wd_q),
    .rdata(mem_rdata)
  );

endmodule

// File: tb/tb_unified_mem_responder.sv
// Bench for unified_mem_responder: a LATENCY=2 instance driven from a vector table and
// a LATENCY=0 instance for the back-to-back stream.
`timescale 1ns/1ps
module tb_unified_mem_responder;

  logic        clk = 1'b0;
  logic        sys_rst, sys_rst0;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic        mem_we, mem_rdy, bus_err;
  logic [31:0] mem_addr0, mem_wdata0, mem_rdata0;
  logic        mem_we0, mem_rdy0, bus_err0;

  always #5 clk = ~clk;

  unified_mem_responder #(.LATENCY(2)) dut (
    .clk(clk), .sys_rst(sys_rst), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_we(mem_we), .mem_rdy(mem_rdy), .mem_rdata(mem_rdata), .bus_err(bus_err)
  );

  unified_mem_responder #(.LATENCY(0)) dut0 (
    .clk(clk), .sys_rst(sys_rst0), .mem_addr(mem_addr0), .mem_wdata(mem_wdata0),
    .mem_we(mem_we0), .mem_rdy(mem_rdy0), .mem_rdata(mem_rdata0), .bus_err(bus_err0)
  );

  typedef struct {
    logic [31:0] addr;
    logic        we;
    logic [31:0] wdata;
    logic [31:0] rdata;   // expected read data at mem_rdy
    logic        chk;     // rdata known (word previously written)
    logic        err;     // expected bus_err while mem_rdy is high
  } vec_t;

  vec_t        vecs[$];
  logic [31:0] exp_q[$];
  logic        chk_q[$];
  int          checks = 0;
  int          failures = 0;
  logic        prev_rdy = 1'b0, prev_rdy0 = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic [31:0] a, input logic w, input logic [31:0] d,
                              input logic [31:0] r, input logic c, input logic e);
    vec_t v;
    v.addr = a; v.we = w; v.wdata = d; v.rdata = r; v.chk = c; v.err = e;
    return v;
  endfunction

  task automatic drive(input logic [31:0] a, input logic w, input logic [31:0] d,
                       input logic [31:0] r, input logic c);
    mem_addr = a; mem_we = w; mem_wdata = d;
    exp_q.push_back(r);
    chk_q.push_back(c);
  endtask

  task automatic wait_rdy(input string name, input int lat, input logic err);
    int   n = 0;
    logic seen = 1'b0;
    logic [31:0] e;
    logic c;
    while (n < 20 && !seen) begin
      @(negedge clk);
      n++;
      if (mem_rdy) seen = 1'b1;
    end
    e = exp_q.pop_front();
    c = chk_q.pop_front();
    if (!seen) begin
      checks++;
      failures++;
      $display("FAIL %s timeout: mem_rdy never seen in 20 cycles, required within %0d", name, lat);
    end else begin
      check({name, " latency"}, 32'(n), 32'(lat));
      if (c) check({name, " rdata"}, mem_rdata, e);
      check({name, " bus_err"}, 32'(bus_err), 32'(err));
    end
  endtask

  task automatic run_vec(input int i, input int lat);
    drive(vecs[i].addr, vecs[i].we, vecs[i].wdata, vecs[i].rdata, vecs[i].chk);
    wait_rdy($sformatf("vec%0d", i), lat, vecs[i].err);
  endtask

  // mem_rdy must never be high on two consecutive cycles
  always @(negedge clk) begin
    if (!sys_rst && mem_rdy) check("rdy_pulse", 32'(prev_rdy), 32'd0);
    if (!sys_rst0 && mem_rdy0) check("rdy0_pulse", 32'(prev_rdy0), 32'd0);
    prev_rdy  = mem_rdy;
    prev_rdy0 = mem_rdy0;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs.push_back(mk(32'h0040_0000, 1'b1, 32'h0000_0013, 32'h0, 1'b0, 1'b0));
    vecs.push_back(mk(32'h0040_0000, 1'b0, 32'h0,         32'h0000_0013, 1'b1, 1'b0));
    vecs.push_back(mk(32'h0040_0008, 1'b1, 32'h1111_1111, 32'h0, 1'b0, 1'b0));
    vecs.push_back(mk(32'h0040_0008, 1'b1, 32'hDEAD_BEEF, 32'h1111_1111, 1'b1, 1'b0));
    vecs.push_back(mk(32'h0040_0008, 1'b0, 32'h0,         32'hDEAD_BEEF, 1'b1, 1'b0));
    vecs.push_back(mk(32'h0040_0004, 1'b1, 32'h4444_4444, 32'h0, 1'b0, 1'b0));
    vecs.push_back(mk(32'h0040_000C, 1'b1, 32'hCCCC_CCCC, 32'h0, 1'b0, 1'b0));
    vecs.push_back(mk(32'h0040_0010, 1'b1, 32'h1010_1010, 32'h0, 1'b0, 1'b0));
    vecs.push_back(mk(32'h0040_0FFC, 1'b1, 32'h0FFC_0FFC, 32'h0, 1'b0, 1'b0));
    vecs.push_back(mk(32'h0040_0FFC, 1'b0, 32'h0,         32'h0FFC_0FFC, 1'b1, 1'b0));
    // after the aborted write: only 0x0C changed
    vecs.push_back(mk(32'h0040_0004, 1'b0, 32'h0,         32'h4444_4444, 1'b1, 1'b0));
    vecs.push_back(mk(32'h0040_000C, 1'b0, 32'h0,         32'h9ABC_DEF0, 1'b1, 1'b0));
    // error accesses: zero data, sticky bus_err, no aliasing onto word 0
    vecs.push_back(mk(32'h0040_1000, 1'b0, 32'h0,         32'h0, 1'b1, 1'b0));
    vecs.push_back(mk(32'h0040_1000, 1'b1, 32'hBAD0_BAD0, 32'h0, 1'b1, 1'b1));
    vecs.push_back(mk(32'h0040_0002, 1'b1, 32'hFFFF_FFFF, 32'h0, 1'b1, 1'b1));
    vecs.push_back(mk(32'h003F_FFFC, 1'b0, 32'h0,         32'h0, 1'b1, 1'b1));
    vecs.push_back(mk(32'h0040_0000, 1'b0, 32'h0,         32'h0000_0013, 1'b1, 1'b1));
    vecs.push_back(mk(32'h0040_0008, 1'b0, 32'h0,         32'hDEAD_BEEF, 1'b1, 1'b1));

    sys_rst = 1'b1; sys_rst0 = 1'b1;
    mem_addr = 32'h0040_0000; mem_we = 1'b0; mem_wdata = 32'h0;
    mem_addr0 = 32'h0040_0020; mem_we0 = 1'b1; mem_wdata0 = 32'hA5A5_5A5A;
    repeat (3) @(negedge clk);
    check("reset rdy", 32'(mem_rdy), 32'd0);
    check("reset rdata", mem_rdata, 32'h0);
    check("reset bus_err", 32'(bus_err), 32'd0);
    sys_rst = 1'b0;

    // first access starts from IDLE, later ones follow a RESP cycle
    for (int i = 0; i < 10; i++) run_vec(i, (i == 0) ? 3 : 4);

    // write to 0x04 abandoned mid-wait in favour of 0x0C
    mem_addr = 32'h0040_0004; mem_we = 1'b1; mem_wdata = 32'h1234_5678;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      check("abort no rdy", 32'(mem_rdy), 32'd0);
    end
    drive(32'h0040_000C, 1'b1, 32'h9ABC_DEF0, 32'hCCCC_CCCC, 1'b1);
    wait_rdy("abort restart", 4, 1'b0);

    for (int i = 10; i < 18; i++) run_vec(i, 4);

    // reset in the middle of a write's wait states
    mem_addr = 32'h0040_0010; mem_we = 1'b1; mem_wdata = 32'h5555_5555;
    @(negedge clk);
    @(negedge clk);
    sys_rst = 1'b1;
    #1;
    check("midrst rdy", 32'(mem_rdy), 32'd0);
    check("midrst rdata", mem_rdata, 32'h0);
    check("midrst bus_err", 32'(bus_err), 32'd0);
    drive(32'h0040_0010, 1'b0, 32'h0, 32'h1010_1010, 1'b1);
    @(negedge clk);
    sys_rst = 1'b0;
    wait_rdy("after reset", 3, 1'b0);
    @(negedge clk);
    check("rdy one cycle", 32'(mem_rdy), 32'd0);
    check("rdata held", mem_rdata, 32'h1010_1010);

    // zero-latency instance: write then a steady read stream
    @(negedge clk);
    sys_rst0 = 1'b0;
    @(negedge clk);
    check("lat0 first rdy", 32'(mem_rdy0), 32'd1);
    mem_addr0 = 32'h0040_0020; mem_we0 = 1'b0; mem_wdata0 = 32'h0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check($sformatf("lat0 rdy%0d", i), 32'(mem_rdy0), 32'(i % 2));
      if (mem_rdy0) check($sformatf("lat0 rdata%0d", i), mem_rdata0, 32'hA5A5_5A5A);
    end
    check("lat0 bus_err", 32'(bus_err0), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
